// File: rtl/nrzi_line_driver.sv
// NRZI line driver: encodes the stuffed USB bitstream onto dp/dm, appends the
// EOP sequence (SE0 then J) and releases the pad output enable afterwards.
module nrzi_line_driver #(
  parameter int unsigned EOP_SE0_BITS = 2,
  parameter int unsigned EOP_J_BITS   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s_in,
  input  logic start_nrzi,
  input  logic done,
  output logic dp,
  output logic dm,
  output logic oe,
  output logic busy,
  output logic eop_done
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    EOP_SE0 = 2'd2,
    EOP_J   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               level_q, level_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dp_q, dp_d;
  logic               dm_q, dm_d;
  logic               oe_q, oe_d;
  logic               eop_done_q, eop_done_d;

  // State, line level, EOP counter and registered pad outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      level_q    <= 1'b1;
      cnt_q      <= '0;
      dp_q       <= 1'b1;
      dm_q       <= 1'b0;
      oe_q       <= 1'b0;
      eop_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      dp_q       <= dp_d;
      dm_q       <= dm_d;
      oe_q       <= oe_d;
      eop_done_q <= eop_done_d;
    end
  end

  // Next-state, NRZI encoding and the line state to present next cycle
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    cnt_d      = cnt_q;
    dp_d       = 1'b1;
    dm_d       = 1'b0;
    oe_d       = 1'b0;
    eop_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // start wins over a coincident done; done alone is ignored here
        if (start_nrzi) begin
          state_d = ACTIVE;
          level_d = 1'b1;
          oe_d    = 1'b1;
        end
      end

      ACTIVE: begin
        oe_d = 1'b1;
        if (done) begin
          // s_in carries no data on the done cycle
          state_d = EOP_SE0;
          cnt_d   = CNT_W'(EOP_SE0_BITS - 1);
          dp_d    = 1'b0;
          dm_d    = 1'b0;
        end else begin
          // A 0 toggles the line, a 1 holds it
          level_d = s_in ? level_q : ~level_q;
          dp_d    = level_d;
          dm_d    = ~level_d;
        end
      end

      EOP_SE0: begin
        oe_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = EOP_J;
          cnt_d   = CNT_W'(EOP_J_BITS - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          dp_d  = 1'b0;
          dm_d  = 1'b0;
        end
      end

      EOP_J: begin
        if (cnt_q == '0) begin
          // Release the bus and flag completion in the first IDLE cycle
          state_d    = IDLE;
          eop_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          oe_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign dp       = dp_q;
  assign dm       = dm_q;
  assign oe       = oe_q;
  assign eop_done = eop_done_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_nrzi_line_driver.sv
// Directed bench for nrzi_line_driver: encoding, EOP timing, ignored pulses,
// reset during EOP and a second instance with longer EOP parameters.
module tb_nrzi_line_driver;

  logic clk = 1'b0;
  logic rst_n;
  logic s_in, start_nrzi, done;
  logic dp, dm, oe, busy, eop_done;
  logic s2_in, start2, done2;
  logic dp2, dm2, oe2, busy2, eop_done2;

  int vectors = 0;
  int errors  = 0;

  // Expected SYNC encoding starting from J
  logic sync_in  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic sync_dp  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  // {dp,dm,oe,busy,eop_done} per cycle after done for SE0=3, J=2
  logic [4:0] eop32_exp [7] = '{5'b00110, 5'b00110, 5'b00110, 5'b10110,
                                5'b10110, 5'b10001, 5'b10000};

  always #5 clk = ~clk;

  nrzi_line_driver #(.EOP_SE0_BITS(2), .EOP_J_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .s_in(s_in), .start_nrzi(start_nrzi), .done(done),
    .dp(dp), .dm(dm), .oe(oe), .busy(busy), .eop_done(eop_done)
  );

  nrzi_line_driver #(.EOP_SE0_BITS(3), .EOP_J_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .s_in(s2_in), .start_nrzi(start2), .done(done2),
    .dp(dp2), .dm(dm2), .oe(oe2), .busy(busy2), .eop_done(eop_done2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ends the current packet on dut and waits (bounded) for eop_done
  task automatic finish_packet(input string name);
    bit seen = 1'b0;
    done = 1'b1; s_in = 1'b0;
    step();
    done = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (eop_done === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      $display("FAIL %s_eop_done: eop_done never seen within 20 cycles, required 1", name);
      errors++;
    end
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_in = 1'b0; start_nrzi = 1'b0; done = 1'b0;
    s2_in = 1'b0; start2 = 1'b0; done2 = 1'b0;
    step(); step();
    vectors++;
    if ({dp, dm, oe, busy, eop_done} !== 5'b10000) begin
      $display("FAIL reset_dut: got %b required 10000", {dp, dm, oe, busy, eop_done});
      errors++;
    end
    vectors++;
    if ({dp2, dm2, oe2, busy2, eop_done2} !== 5'b10000) begin
      $display("FAIL reset_dut2: got %b required 10000", {dp2, dm2, oe2, busy2, eop_done2});
      errors++;
    end
    rst_n = 1'b1;
    step();
    vectors++;
    if ({dp, dm, oe, busy, eop_done} !== 5'b10000) begin
      $display("FAIL idle_after_reset: got %b required 10000", {dp, dm, oe, busy, eop_done});
      errors++;
    end
  endtask

  task automatic test_sync();
    start_nrzi = 1'b1;
    step();
    start_nrzi = 1'b0;
    vectors++;
    if ({dp, dm, oe, busy, eop_done} !== 5'b10110) begin
      $display("FAIL sync_first_j: got %b required 10110", {dp, dm, oe, busy, eop_done});
      errors++;
    end
    for (int i = 0; i < 8; i++) begin
      s_in = sync_in[i];
      step();
      vectors++;
      if ({dp, dm, oe, busy} !== {sync_dp[i], ~sync_dp[i], 2'b11}) begin
        $display("FAIL sync_bit%0d: got %b required %b", i, {dp, dm, oe, busy},
                 {sync_dp[i], ~sync_dp[i], 2'b11});
        errors++;
      end
    end
  endtask

  // Continues the packet from test_sync (line currently K)
  task automatic test_hold_eop();
    logic [4:0] exp [5] = '{5'b00110, 5'b00110, 5'b10110, 5'b10001, 5'b10000};
    for (int i = 0; i < 8; i++) begin
      s_in = 1'b1;
      step();
      vectors++;
      if ({dp, dm, oe} !== 3'b011) begin
        $display("FAIL hold_one%0d: got %b required 011", i, {dp, dm, oe});
        errors++;
      end
    end
    done = 1'b1; s_in = 1'b0;
    step();
    done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({dp, dm, oe, busy, eop_done} !== exp[i]) begin
        $display("FAIL eop_cycle%0d: got %b required %b", i, {dp, dm, oe, busy, eop_done}, exp[i]);
        errors++;
      end
      if (i < 4) step();
    end
  endtask

  task automatic test_stuffed();
    start_nrzi = 1'b1;
    step();
    start_nrzi = 1'b0;
    s_in = 1'b0;
    step();
    vectors++;
    if ({dp, dm} !== 2'b01) begin
      $display("FAIL stuff_k: got %b required 01", {dp, dm});
      errors++;
    end
    for (int i = 0; i < 6; i++) begin
      s_in = 1'b1;
      step();
      vectors++;
      if ({dp, dm} !== 2'b01) begin
        $display("FAIL stuff_hold%0d: got %b required 01", i, {dp, dm});
        errors++;
      end
    end
    s_in = 1'b0;
    step();
    vectors++;
    if ({dp, dm} !== 2'b10) begin
      $display("FAIL stuff_toggle: got %b required 10", {dp, dm});
      errors++;
    end
    finish_packet("stuffed");
  endtask

  task automatic test_ignored_pulses();
    start_nrzi = 1'b1;
    step();
    start_nrzi = 1'b0;
    s_in = 1'b0;
    step();
    // Restart attempt while ACTIVE with s_in=1: line must stay K
    start_nrzi = 1'b1; s_in = 1'b1;
    step();
    start_nrzi = 1'b0;
    vectors++;
    if ({dp, dm, oe, busy} !== 4'b0111) begin
      $display("FAIL restart_ignored: got %b required 0111", {dp, dm, oe, busy});
      errors++;
    end
    s_in = 1'b0;
    step();
    vectors++;
    if ({dp, dm, oe, busy} !== 4'b1011) begin
      $display("FAIL after_restart_toggle: got %b required 1011", {dp, dm, oe, busy});
      errors++;
    end
    finish_packet("ignored");
    done = 1'b1;
    step();
    done = 1'b0;
    vectors++;
    if ({dp, dm, oe, busy, eop_done} !== 5'b10000) begin
      $display("FAIL idle_done_ignored: got %b required 10000", {dp, dm, oe, busy, eop_done});
      errors++;
    end
    step();
    vectors++;
    if ({dp, dm, oe, busy, eop_done} !== 5'b10000) begin
      $display("FAIL idle_done_no_eop: got %b required 10000", {dp, dm, oe, busy, eop_done});
      errors++;
    end
    start_nrzi = 1'b1; done = 1'b1;
    step();
    start_nrzi = 1'b0; done = 1'b0;
    vectors++;
    if ({dp, dm, oe, busy, eop_done} !== 5'b10110) begin
      $display("FAIL start_wins: got %b required 10110", {dp, dm, oe, busy, eop_done});
      errors++;
    end
    s_in = 1'b0;
    step();
    vectors++;
    if ({dp, dm, oe, busy} !== 4'b0111) begin
      $display("FAIL start_wins_encode: got %b required 0111", {dp, dm, oe, busy});
      errors++;
    end
    finish_packet("start_wins");
  endtask

  task automatic test_reset_mid_eop();
    start_nrzi = 1'b1;
    step();
    start_nrzi = 1'b0;
    s_in = 1'b0;
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    vectors++;
    if ({dp, dm, oe, busy} !== 4'b0011) begin
      $display("FAIL se0_second: got %b required 0011", {dp, dm, oe, busy});
      errors++;
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({dp, dm, oe, busy, eop_done} !== 5'b10000) begin
      $display("FAIL async_reset: got %b required 10000", {dp, dm, oe, busy, eop_done});
      errors++;
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({dp, dm, oe, busy, eop_done} !== 5'b10000) begin
        $display("FAIL post_reset_idle%0d: got %b required 10000", i, {dp, dm, oe, busy, eop_done});
        errors++;
      end
    end
    start_nrzi = 1'b1;
    step();
    start_nrzi = 1'b0;
    vectors++;
    if ({dp, dm, oe, busy} !== 4'b1011) begin
      $display("FAIL restart_after_reset: got %b required 1011", {dp, dm, oe, busy});
      errors++;
    end
    s_in = 1'b0;
    step();
    vectors++;
    if ({dp, dm, oe, busy} !== 4'b0111) begin
      $display("FAIL encode_after_reset: got %b required 0111", {dp, dm, oe, busy});
      errors++;
    end
    finish_packet("after_reset");
  endtask

  task automatic test_eop_params();
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    s2_in = 1'b0;
    step();
    vectors++;
    if ({dp2, dm2, oe2, busy2} !== 4'b0111) begin
      $display("FAIL p32_k: got %b required 0111", {dp2, dm2, oe2, busy2});
      errors++;
    end
    done2 = 1'b1;
    step();
    done2 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if ({dp2, dm2, oe2, busy2, eop_done2} !== eop32_exp[i]) begin
        $display("FAIL p32_eop%0d: got %b required %b", i,
                 {dp2, dm2, oe2, busy2, eop_done2}, eop32_exp[i]);
        errors++;
      end
      if (i < 6) step();
    end
  endtask

  initial begin
    test_reset();
    test_sync();
    test_hold_eop();
    test_stuffed();
    test_ignored_pulses();
    test_reset_mid_eop();
    test_eop_params();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/nrzi_line_driver.md
Name: nrzi_line_driver

Overview:
Downstream neighbour of the bit stuffer in the USB transmit path. Consumes the stuffed serial bitstream (s_in), the start_nrzi pulse and the done pulse. NRZI-encodes each bit onto the differential pair (dp/dm) and appends the End-Of-Packet sequence: SE0 for a set number of bit times, then J. Controls the pad output enable so the bus is released once the packet is finished.

Parameters:
EOP_SE0_BITS, 2, number of bit times dp=dm=0 is driven for EOP (range 1..15)
EOP_J_BITS, 1, number of bit times J is driven after SE0 before release (range 1..15)

Ports:
clk  input  1  bit-rate clock
rst_n  input  1  reset, asynchronous, active-low
s_in  input  1  stuffed serial bit from the bit stuffer (s_out); don't-care/Z outside ACTIVE
start_nrzi  input  1  one-cycle pulse: packet transmission begins; first data bit arrives next cycle
done  input  1  one-cycle pulse: packet ended; s_in in this cycle carries no data
dp  output  1  D+ line level
dm  output  1  D- line level
oe  output  1  pad output enable, 1 = block drives the bus
busy  output  1  1 whenever state != IDLE
eop_done  output  1  one-cycle pulse in the first IDLE cycle after EOP completes

Behaviour:
- Clock/reset: clk; reset rst_n, asynchronous, active-low. Asserting reset at any time, including mid-packet or mid-EOP, forces reset values immediately.
- Reset values:
  - state=IDLE, level_q=1, dp=1, dm=0 (J).
  - oe=0, busy=0, eop_done=0, EOP counter=0.
- dp, dm, oe and eop_done are registered outputs. busy is decoded from the state register.
- States: IDLE, ACTIVE, EOP_SE0, EOP_J.
- IDLE:
  - dp=1, dm=0, oe=0.
  - start_nrzi=1 → ACTIVE; level_q set to 1 (J), oe=1 from the next cycle.
  - done in IDLE is ignored.
  - If start_nrzi and done are high in the same cycle, start_nrzi wins.
- ACTIVE, done=0:
  - s_in=0 → level_q toggles; s_in=1 → level_q holds.
  - dp=level_q, dm=~level_q.
  - Latency: bit sampled in cycle n appears on dp/dm in cycle n+1.
  - The first ACTIVE cycle shows J with oe=1.
- ACTIVE, done=1:
  - s_in is not encoded; level_q unchanged.
  - Next state EOP_SE0; counter loaded with EOP_SE0_BITS-1.
- EOP_SE0:
  - dp=0, dm=0, oe=1; counter decrements each cycle.
  - At counter=0 → EOP_J; counter loaded with EOP_J_BITS-1.
- EOP_J:
  - dp=1, dm=0, oe=1; counter decrements each cycle.
  - At counter=0 → IDLE; in the first IDLE cycle oe=0 and eop_done=1 for exactly one cycle.
- start_nrzi outside IDLE is ignored (no restart). done outside ACTIVE is ignored.
- Counter width: 4 bits; no wrap is possible within the legal parameter range.
- Line states: J = dp1/dm0; K = dp0/dm1; SE0 = dp0/dm0. dp=dm=1 is never produced.

Test Plan:
1. Reset, pulse start_nrzi, then s_in = 0,0,0,0,0,0,0,1 (SYNC) on consecutive cycles → dp from the cycle after the first bit: 0,1,0,1,0,1,0,0 (K J K J K J K K); dm is the complement; oe=1 throughout; busy=1.
2. After SYNC, send eight 1s, then pulse done → dp/dm hold the last level for 8 cycles. Then exactly 2 cycles dp=0/dm=0, 1 cycle dp=1/dm=0 with oe=1. Next cycle: oe=0, eop_done=1 (one cycle only), busy=0.
3. Stuffed pattern 1,1,1,1,1,1,0 starting from level K → dp held at 0 for 6 cycles, then 1 on the cycle after the stuffed 0.
4. Pulse start_nrzi mid-ACTIVE → encoding unaffected, no level reset. Pulse done in IDLE → no EOP, oe stays 0. Pulse start_nrzi and done in the same IDLE cycle → enters ACTIVE.
5. Assert rst_n=0 during the second EOP_SE0 cycle → dp=1, dm=0, oe=0, busy=0 immediately, with no eop_done pulse. After release, the block accepts a new start_nrzi normally.
6. With EOP_SE0_BITS=3, EOP_J_BITS=2 → SE0 for 3 cycles, then J with oe=1 for 2 cycles, then release with eop_done pulse.
